// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: ALU opcodes, major opcodes, skid-buffer states.
// No logic; no latency; no flow control.
// Consumed by alu_issue_decode and alu_issue_stage.
package riscvPkg;

    typedef enum logic [3:0] {
        AluAdd  = 4'b0000,
        AluSll  = 4'b0001,
        AluSlt  = 4'b0010,
        AluSltu = 4'b0011,
        AluXor  = 4'b0100,
        AluSrl  = 4'b0101,
        AluOr   = 4'b0110,
        AluAnd  = 4'b0111,
        AluSub  = 4'b1000,
        AluSra  = 4'b1101
    } alu_op_e;

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;

    localparam logic [6:0] Funct7Zero = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    typedef enum logic [1:0] {
        SkidEmpty = 2'd0,
        SkidFull1 = 2'd1,
        SkidFull2 = 2'd2
    } skid_state_e;

    // OP-IMM shifts take a 5-bit shamt instead of the 12-bit immediate.
    function automatic logic is_imm_shift(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational RV32I OP/OP-IMM decoder: instr + rs data -> {illegal, op, a, b}.
// Zero latency; no state, no flow control.
// Caller decides what to do with illegal encodings.
module alu_issue_decode
    import riscvPkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            illegal,
    output alu_op_e         op,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_rd;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign unused_rd = ^instr[11:7];

    always_comb begin
        illegal = 1'b1;
        op      = AluAdd;
        a       = rs1;
        b       = rs2;
        case (opcode)
            OpcOp: begin
                // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
                if ((funct7 == Funct7Zero) ||
                    ((funct7 == Funct7Alt) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
                    illegal = 1'b0;
                    op      = alu_op_e'({funct7[5], funct3});
                end
            end
            OpcOpImm: begin
                b = {{(XLEN-12){instr[31]}}, instr[31:20]};
                if (is_imm_shift(funct3)) begin
                    b = {{(XLEN-5){1'b0}}, instr[24:20]};
                    if ((funct7 == Funct7Zero) ||
                        ((funct7 == Funct7Alt) && (funct3 == 3'b101))) begin
                        illegal = 1'b0;
                        op      = alu_op_e'({(funct3 == 3'b101) ? instr[30] : 1'b0, funct3});
                    end
                end else begin
                    illegal = 1'b0;
                    op      = alu_op_e'({1'b0, funct3});
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes OP/OP-IMM and drives ALU op/A/B via a 2-entry skid buffer.
// Latency 1 cycle when empty; illegal instructions are dropped and pulse o_illegal.
// Backpressure: o_instr_ready is registered, low only when both entries are full.
// Optional ALU_ISSUE_STALL_COUNT_EN adds a saturating o_stall_count.
module alu_issue_stage
    import riscvPkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_instr_valid,
    output logic            o_instr_ready,
    input  logic [31:0]     i_instr_data,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic            o_op_valid,
    input  logic            i_op_ready,
    output logic [3:0]      o_op_data,
    output logic            o_a_valid,
    output logic [XLEN-1:0] o_a_data,
    output logic            o_b_valid,
    output logic [XLEN-1:0] o_b_data,
`ifdef ALU_ISSUE_STALL_COUNT_EN
    output logic [31:0]     o_stall_count,
`endif
    output logic            o_illegal
);

    logic            dec_illegal;
    alu_op_e         dec_op;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;

    alu_issue_decode #(.XLEN(XLEN)) u_decode (
        .instr   (i_instr_data),
        .rs1     (i_rs1_data),
        .rs2     (i_rs2_data),
        .illegal (dec_illegal),
        .op      (dec_op),
        .a       (dec_a),
        .b       (dec_b)
    );

    skid_state_e     state_q;
    skid_state_e     state_d;
    logic            ready_q;
    logic            illegal_q;
    logic [3:0]      out_op_q;
    logic [XLEN-1:0] out_a_q;
    logic [XLEN-1:0] out_b_q;
    logic [3:0]      skid_op_q;
    logic [XLEN-1:0] skid_a_q;
    logic [XLEN-1:0] skid_b_q;

    logic in_xfer;
    logic legal_in;
    logic out_xfer;
    logic load_out_in;
    logic load_out_skid;
    logic load_skid;

    assign in_xfer  = i_instr_valid & ready_q;
    assign legal_in = in_xfer & ~dec_illegal;
    assign out_xfer = o_op_valid & i_op_ready;

    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            SkidEmpty: begin
                if (legal_in) begin
                    state_d     = SkidFull1;
                    load_out_in = 1'b1;
                end
            end
            SkidFull1: begin
                if (legal_in && out_xfer) begin
                    load_out_in = 1'b1;
                end else if (legal_in) begin
                    state_d   = SkidFull2;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_d = SkidEmpty;
                end
            end
            SkidFull2: begin
                if (out_xfer) begin
                    state_d       = SkidFull1;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = SkidEmpty;
        endcase
    end

    // Ready comes from the next state so it never depends combinationally on i_op_ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= SkidEmpty;
            ready_q   <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= (state_d != SkidFull2);
            illegal_q <= in_xfer & dec_illegal;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_op_q  <= '0;
            out_a_q   <= '0;
            out_b_q   <= '0;
            skid_op_q <= '0;
            skid_a_q  <= '0;
            skid_b_q  <= '0;
        end else begin
            if (load_out_in) begin
                out_op_q <= dec_op;
                out_a_q  <= dec_a;
                out_b_q  <= dec_b;
            end else if (load_out_skid) begin
                out_op_q <= skid_op_q;
                out_a_q  <= skid_a_q;
                out_b_q  <= skid_b_q;
            end
            if (load_skid) begin
                skid_op_q <= dec_op;
                skid_a_q  <= dec_a;
                skid_b_q  <= dec_b;
            end
        end
    end

`ifdef ALU_ISSUE_STALL_COUNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
        end else if (o_op_valid && !i_op_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign o_stall_count = stall_q;
`endif

    assign o_instr_ready = ready_q;
    assign o_op_valid    = (state_q != SkidEmpty);
    assign o_a_valid     = o_op_valid;
    assign o_b_valid     = o_op_valid;
    assign o_op_data     = out_op_q;
    assign o_a_data      = out_a_q;
    assign o_b_data      = out_b_q;
    assign o_illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_instr_valid = 1'b0;
    logic        o_instr_ready;
    logic [31:0] i_instr_data = '0;
    logic [31:0] i_rs1_data = '0;
    logic [31:0] i_rs2_data = '0;
    logic        o_op_valid;
    logic        i_op_ready = 1'b0;
    logic [3:0]  o_op_data;
    logic        o_a_valid;
    logic [31:0] o_a_data;
    logic        o_b_valid;
    logic [31:0] o_b_data;
    logic        o_illegal;
`ifdef ALU_ISSUE_STALL_COUNT_EN
    logic [31:0] o_stall_count;
`endif

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_instr_valid (i_instr_valid),
        .o_instr_ready (o_instr_ready),
        .i_instr_data  (i_instr_data),
        .i_rs1_data    (i_rs1_data),
        .i_rs2_data    (i_rs2_data),
        .o_op_valid    (o_op_valid),
        .i_op_ready    (i_op_ready),
        .o_op_data     (o_op_data),
        .o_a_valid     (o_a_valid),
        .o_a_data      (o_a_data),
        .o_b_valid     (o_b_valid),
        .o_b_data      (o_b_data),
`ifdef ALU_ISSUE_STALL_COUNT_EN
        .o_stall_count (o_stall_count),
`endif
        .o_illegal     (o_illegal)
    );

    // Reference decode written directly from the ISA rules.
    function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] r2,
                                       output logic ill, output logic [3:0] op,
                                       output logic [31:0] b);
        logic [2:0] f3;
        logic [6:0] f7;
        f3  = ins[14:12];
        f7  = ins[31:25];
        ill = 1'b1;
        op  = 4'd0;
        b   = r2;
        if (ins[6:0] == 7'b0110011) begin
            ill = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            op  = {f7[5], f3};
        end else if (ins[6:0] == 7'b0010011) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                b   = {27'd0, ins[24:20]};
                ill = !((f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5));
                op  = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
            end else begin
                b   = 32'($signed(ins[31:20]));
                ill = 1'b0;
                op  = {1'b0, f3};
            end
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  f7;
        int          sel;
        int          k;
        r   = $urandom;
        sel = $urandom_range(0, 9);
        k   = $urandom_range(0, 3);
        f7  = (k < 2) ? 7'h00 : (k == 2) ? 7'h20 : r[31:25];
        if (sel < 5)      return {f7, r[24:7], 7'b0110011};
        else if (sel < 9) return {f7, r[24:7], 7'b0010011};
        else              return r;
    endfunction

    // Drives one instruction for a single cycle; returns just after the accepting edge.
    task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        i_instr_valid = 1'b1;
        i_instr_data  = ins;
        i_rs1_data    = r1;
        i_rs2_data    = r2;
        @(posedge clk);
        #1;
        i_instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++; if (o_op_valid !== 1'b0) $display("FAIL reset_op_valid: got %b want 0", o_op_valid); else passes++;
        checks++; if (o_a_valid !== 1'b0 || o_b_valid !== 1'b0) $display("FAIL reset_ab_valid: got %b%b want 00", o_a_valid, o_b_valid); else passes++;
        checks++; if (o_illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", o_illegal); else passes++;
        checks++; if (o_instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_instr_ready); else passes++;
        checks++; if ({o_op_data, o_a_data, o_b_data} !== 68'd0) $display("FAIL reset_data: got %h/%h/%h want 0", o_op_data, o_a_data, o_b_data); else passes++;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_decode();
        i_op_ready = 1'b1;
        issue(32'h002081B3, 32'd5, 32'd7);
        checks++; if (o_op_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", o_op_valid); else passes++;
        checks++; if ({o_op_data, o_a_data, o_b_data} !== {4'h0, 32'd5, 32'd7}) $display("FAIL add_data: got %h/%h/%h want 0/5/7", o_op_data, o_a_data, o_b_data); else passes++;
        @(posedge clk); #1;
        checks++; if (o_op_valid !== 1'b0) $display("FAIL add_drain: got %b want 0", o_op_valid); else passes++;
        issue(32'hFFF00093, 32'd0, 32'h1234);
        checks++; if ({o_op_data, o_a_data, o_b_data} !== {4'h0, 32'd0, 32'hFFFF_FFFF}) $display("FAIL addi_data: got %h/%h/%h want 0/0/ffffffff", o_op_data, o_a_data, o_b_data); else passes++;
        @(posedge clk); #1;
        issue(32'h4040D093, 32'h8000_0000, 32'd0);
        checks++; if ({o_op_data, o_a_data, o_b_data} !== {4'hD, 32'h8000_0000, 32'd4}) $display("FAIL srai_data: got %h/%h/%h want d/80000000/4", o_op_data, o_a_data, o_b_data); else passes++;
        issue(32'h40208133, 32'd9, 32'd4);
        checks++; if ({o_op_valid, o_op_data, o_a_data, o_b_data} !== {1'b1, 4'h8, 32'd9, 32'd4}) $display("FAIL sub_data: got %b %h/%h/%h want 1 8/9/4", o_op_valid, o_op_data, o_a_data, o_b_data); else passes++;
        @(posedge clk); #1;
        checks++; if (o_op_valid !== 1'b0) $display("FAIL sub_drain: got %b want 0", o_op_valid); else passes++;
    endtask

    task automatic test_back_to_back();
`ifdef ALU_ISSUE_STALL_COUNT_EN
        logic [31:0] stall0;
        stall0 = o_stall_count;
`endif
        i_op_ready = 1'b0;
        issue(32'h002081B3, 32'd1, 32'd2);
        issue(32'h40208133, 32'd10, 32'd3);
        checks++; if (o_instr_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", o_instr_ready); else passes++;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({o_op_valid, o_op_data, o_a_data, o_b_data} !== {1'b1, 4'h0, 32'd1, 32'd2}) $display("FAIL bp_hold%0d: got %b %h/%h/%h want 1 0/1/2", i, o_op_valid, o_op_data, o_a_data, o_b_data); else passes++;
            @(posedge clk); #1;
        end
        checks++; if ({o_op_valid, o_op_data, o_a_data, o_b_data, o_instr_ready} !== {1'b1, 4'h0, 32'd1, 32'd2, 1'b0}) $display("FAIL bp_hold_last: got %b %h/%h/%h rdy %b", o_op_valid, o_op_data, o_a_data, o_b_data, o_instr_ready); else passes++;
`ifdef ALU_ISSUE_STALL_COUNT_EN
        checks++; if (o_stall_count !== stall0 + 32'd3) $display("FAIL bp_stall_count: got %0d want %0d", o_stall_count, stall0 + 32'd3); else passes++;
`endif
        i_op_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({o_op_valid, o_op_data, o_a_data, o_b_data} !== {1'b1, 4'h8, 32'd10, 32'd3}) $display("FAIL bp_second: got %b %h/%h/%h want 1 8/a/3", o_op_valid, o_op_data, o_a_data, o_b_data); else passes++;
        checks++; if (o_instr_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", o_instr_ready); else passes++;
        @(posedge clk); #1;
        checks++; if (o_op_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", o_op_valid); else passes++;
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2];
        bad[0] = 32'h00000073;
        bad[1] = 32'h40109093;
        i_op_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(bad[i], 32'd1, 32'd2);
            checks++; if ({o_illegal, o_op_valid} !== 2'b10) $display("FAIL illegal%0d_pulse: got ill %b vld %b want 1 0", i, o_illegal, o_op_valid); else passes++;
            @(posedge clk); #1;
            checks++; if ({o_illegal, o_op_valid} !== 2'b00) $display("FAIL illegal%0d_end: got ill %b vld %b want 0 0", i, o_illegal, o_op_valid); else passes++;
        end
    endtask

    task automatic test_reset_mid();
        i_op_ready = 1'b0;
        issue(32'h002081B3, 32'h11, 32'h22);
        issue(32'h002081B3, 32'h33, 32'h44);
        checks++; if (o_instr_ready !== 1'b0) $display("FAIL rst_mid_full2: got rdy %b want 0", o_instr_ready); else passes++;
        #2;
        rstn = 1'b0;
        #1;
        checks++; if ({o_op_valid, o_a_valid, o_b_valid} !== 3'b000) $display("FAIL rst_mid_valid: got %b%b%b want 000", o_op_valid, o_a_valid, o_b_valid); else passes++;
        checks++; if ({o_a_data, o_b_data} !== 64'd0) $display("FAIL rst_mid_data: got %h/%h want 0", o_a_data, o_b_data); else passes++;
        @(negedge clk);
        rstn = 1'b1;
        i_op_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if ({o_op_valid, o_instr_ready} !== 2'b01) $display("FAIL rst_mid_after%0d: got vld %b rdy %b want 0 1", i, o_op_valid, o_instr_ready); else passes++;
        end
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic        exp_ill;
        logic        exp_ill_next;
        logic        ill;
        logic [3:0]  op;
        logic [31:0] b;
        logic [31:0] stall_model;
        stall_model = 32'd0;
        exp_ill     = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (cyc < 1150) begin
                i_instr_valid = ($urandom_range(0, 3) != 0);
                i_instr_data  = rand_instr();
                i_rs1_data    = $urandom;
                i_rs2_data    = $urandom;
                i_op_ready    = ($urandom_range(0, 2) != 0);
            end else begin
                i_instr_valid = 1'b0;
                i_op_ready    = 1'b1;
            end
            @(negedge clk);
            exp_ill_next = 1'b0;
            checks++; if (o_op_valid !== (q.size() > 0)) $display("FAIL rnd_valid c%0d: got %b want %b", cyc, o_op_valid, q.size() > 0); else passes++;
            checks++; if (o_instr_ready !== (q.size() < 2)) $display("FAIL rnd_ready c%0d: got %b want %b", cyc, o_instr_ready, q.size() < 2); else passes++;
            checks++; if ({o_a_valid, o_b_valid} !== {2{o_op_valid}}) $display("FAIL rnd_ab_valid c%0d: got %b%b want %b", cyc, o_a_valid, o_b_valid, o_op_valid); else passes++;
            checks++; if (o_illegal !== exp_ill) $display("FAIL rnd_illegal c%0d: got %b want %b", cyc, o_illegal, exp_ill); else passes++;
`ifdef ALU_ISSUE_STALL_COUNT_EN
            checks++; if (o_stall_count !== stall_model) $display("FAIL rnd_stall c%0d: got %0d want %0d", cyc, o_stall_count, stall_model); else passes++;
            if (q.size() > 0 && !i_op_ready && stall_model != 32'hFFFF_FFFF) stall_model++;
`endif
            if (q.size() > 0) begin
                e = q[0];
                checks++; if ({o_op_data, o_a_data, o_b_data} !== {e.op, e.a, e.b}) $display("FAIL rnd_data c%0d: got %h/%h/%h want %h/%h/%h", cyc, o_op_data, o_a_data, o_b_data, e.op, e.a, e.b); else passes++;
                if (i_op_ready) void'(q.pop_front());
            end
            if (i_instr_valid && (q.size() < 2 || (q.size() == 2 && 1'b0)) && o_instr_ready) begin
                ref_decode(i_instr_data, i_rs2_data, ill, op, b);
                if (ill) exp_ill_next = 1'b1;
                else begin
                    e.op = op;
                    e.a  = i_rs1_data;
                    e.b  = b;
                    q.push_back(e);
                end
            end
            exp_ill = exp_ill_next;
            @(posedge clk); #1;
        end
        checks++; if (q.size() != 0) $display("FAIL rnd_drain: %0d entries undelivered, want 0", q.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
